// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, bit shifting on
// device clock falls, ACK check, completion/failure pulses.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t      state, state_n;
  logic        clk_s1, clk_s2, clk_s3;
  logic        dat_s1, dat_s2;
  logic        fall;
  logic [7:0]  shreg;
  logic        par;
  logic [3:0]  bitcnt;
  logic        dat_drv;
  logic [31:0] cnt;
  logic        tmo;
  logic        inh_end;
  logic        accept;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        shift;
  logic        to_send;
  logic        done_n;
  logic        error_n;

  // Two-flop synchronizers plus a delayed copy of the clock for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= ps2_dat_in;
      dat_s2 <= dat_s1;
    end
  end

  assign fall    = clk_s3 & ~clk_s2;
  assign tmo     = (cnt == 32'(TIMEOUT_CYCLES - 1));
  assign inh_end = (cnt == 32'(INHIBIT_CYCLES - 1));

  // State register and registered completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      done  <= done_n;
      error <= error_n;
    end
  end

  // Next-state and control decode
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    shift   = 1'b0;
    to_send = 1'b0;
    done_n  = 1'b0;
    error_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (send) begin
          accept  = 1'b1;
          cnt_clr = 1'b1;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        cnt_inc = 1'b1;
        if (inh_end) state_n = REQ;
      end
      REQ: begin
        cnt_clr = 1'b1;
        to_send = 1'b1;
        state_n = SEND;
      end
      SEND: begin
        cnt_inc = 1'b1;
        if (tmo) begin
          error_n = 1'b1;
          state_n = IDLE;
        end else if (fall) begin
          shift = 1'b1;
          if (bitcnt == 4'd9) state_n = ACK;
        end
      end
      ACK: begin
        cnt_inc = 1'b1;
        if (tmo) begin
          error_n = 1'b1;
          state_n = IDLE;
        end else if (fall) begin
          if (dat_s2) begin
            error_n = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_inc = 1'b1;
        if (tmo) begin
          error_n = 1'b1;
          state_n = IDLE;
        end else if (clk_s2 && dat_s2) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Shared inhibit/timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_inc) begin
      cnt <= cnt + 32'd1;
    end
  end

  // Byte latch, bit shifting and data-line drive bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      par     <= 1'b0;
      bitcnt  <= '0;
      dat_drv <= 1'b0;
    end else if (accept) begin
      shreg   <= data_in;
      par     <= ~^data_in;
      bitcnt  <= '0;
      dat_drv <= 1'b0;
    end else if (to_send) begin
      dat_drv <= 1'b1;
    end else if (shift) begin
      bitcnt <= bitcnt + 4'd1;
      if (bitcnt < 4'd8) begin
        dat_drv <= ~shreg[0];
        shreg   <= {1'b0, shreg[7:1]};
      end else if (bitcnt == 4'd8) begin
        dat_drv <= ~par;
      end else begin
        dat_drv <= 1'b0;
      end
    end
  end

  assign busy       = (state != IDLE);
  assign ps2_clk_oe = (state == INHIBIT) || (state == REQ);
  assign ps2_dat_oe = (state == REQ) || ((state == SEND) && dat_drv);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector line model plus a PS/2
// device model that clocks the frame, captures bits and ACKs.
module tb_ps2_host_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        dev_clk_lo = 1'b0;
  logic        dev_dat_lo = 1'b0;
  logic        ps2_clk_in;
  logic        ps2_dat_in;
  logic        ps2_clk_oe;
  logic        ps2_dat_oe;
  logic        busy;
  logic        done;
  logic        error;

  int vectors = 0;
  int miscompares = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;

  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_lo);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_lo);

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .TIMEOUT_CYCLES(4000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .send      (send),
    .data_in   (data_in),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) n_done++;
    if (error) n_err++;
    if (done && error) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_send(input logic [7:0] b);
    @(negedge clk);
    data_in = b;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
  endtask

  // act: 0 none, 1 send 0x00 during bit 4, 2 reset during bit 4
  task automatic dev_xfer(input bit nack, input int act,
                          output logic [10:0] cap);
    int t;
    cap = '0;
    t = 0;
    while (!(ps2_clk_in && !ps2_dat_in && busy) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("req_seen", 32'(ps2_clk_in && !ps2_dat_in && busy), 32'd1);
    if (t >= 300) return;
    cap[0] = ps2_dat_in;
    for (int i = 1; i <= 10; i++) begin
      cyc(40);
      dev_clk_lo = 1'b1;
      if (i == 4 && act == 1) begin
        data_in = 8'h00;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        cyc(39);
      end else if (i == 4 && act == 2) begin
        rst_n = 1'b0;
        #1;
        chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dev_clk_lo = 1'b0;
        return;
      end else begin
        cyc(40);
      end
      dev_clk_lo = 1'b0;
      cap[i] = ps2_dat_in;
    end
    cyc(20);
    dev_dat_lo = !nack;
    cyc(20);
    dev_clk_lo = 1'b1;
    cyc(40);
    dev_clk_lo = 1'b0;
    cyc(20);
    dev_dat_lo = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (busy && t < 2000) begin
      cyc(1);
      t++;
    end
    chk(tag, 32'(busy), 32'd0);
    cyc(2);
  endtask

  task automatic xfer(input string tag, input logic [7:0] b,
                      input logic [10:0] exp, input int act);
    logic [10:0] cap;
    int d0, e0;
    d0 = n_done;
    e0 = n_err;
    pulse_send(b);
    dev_xfer(1'b0, act, cap);
    wait_idle({tag, "_idle"});
    chk({tag, "_frame"}, 32'(cap), 32'(exp));
    chk({tag, "_done"}, 32'(n_done - d0), 32'd1);
    chk({tag, "_err"}, 32'(n_err - e0), 32'd0);
    chk({tag, "_oe"}, 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
  endtask

  initial begin
    logic [10:0] cap;
    int d0, e0, n, h, f;

    cyc(3);
    chk("rst_busy0", 32'(busy), 32'd0);
    chk("rst_oe0", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    chk("rst_pulses0", 32'({done, error}), 32'd0);
    rst_n = 1'b1;
    cyc(3);

    // frames are {stop, parity, data, start}
    xfer("ed", 8'hED, {1'b1, 1'b1, 8'hED, 1'b0}, 0);
    xfer("f4", 8'hF4, {1'b1, 1'b0, 8'hF4, 1'b0}, 0);
    xfer("00", 8'h00, {1'b1, 1'b1, 8'h00, 1'b0}, 0);

    d0 = n_done;
    e0 = n_err;
    pulse_send(8'hF4);
    dev_xfer(1'b1, 0, cap);
    wait_idle("nack_idle");
    chk("nack_err", 32'(n_err - e0), 32'd1);
    chk("nack_done", 32'(n_done - d0), 32'd0);
    chk("nack_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);

    e0 = n_err;
    pulse_send(8'h00);
    n = 0;
    while (!(ps2_dat_oe && !ps2_clk_oe) && n < 100) begin
      cyc(1);
      n++;
    end
    chk("tmo_send", 32'(ps2_dat_oe && !ps2_clk_oe), 32'd1);
    n = 0;
    while (!error && n < 5000) begin
      cyc(1);
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'd4000);
    chk("tmo_busy", 32'(busy), 32'd0);
    cyc(2);
    chk("tmo_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    chk("tmo_err", 32'(n_err - e0), 32'd1);

    xfer("mid", 8'hED, {1'b1, 1'b1, 8'hED, 1'b0}, 1);

    pulse_send(8'hED);
    dev_xfer(1'b0, 2, cap);
    cyc(5);
    chk("rst_idle", 32'(busy), 32'd0);
    xfer("ff", 8'hFF, {1'b1, 1'b1, 8'hFF, 1'b0}, 0);

    @(negedge clk);
    data_in = 8'hF4;
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    chk("inh_busy", 32'(busy), 32'd1);
    h = 0;
    f = 0;
    while (ps2_clk_oe && h < 100) begin
      h++;
      if (ps2_dat_oe && f == 0) f = h;
      cyc(1);
    end
    chk("inh_len", 32'(h), 32'd21);
    chk("inh_dat", 32'(f), 32'd21);
    dev_xfer(1'b0, 0, cap);
    wait_idle("inh_idle");
    chk("inh_frame", 32'(cap), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));

    chk("never_both", 32'(n_both), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
